// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Fetch FSM encoding plus the width, reset-vector and HLT defaults.
package instr_fetch_pkg;

   localparam int          ADDR_WIDTH_D = 16;
   localparam logic [15:0] RESET_PC_D   = 16'h0000;
   localparam logic [3:0]  HLT_OPCODE_D = 4'hF;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ifid_reg.sv
// IF/ID pipeline register: load-enable, squash and async reset.
// Squash only drops valid; the held word and PC+2 are kept.
module instr_fetch_ifid_reg
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_D
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic                  i_squash,
   input  logic [15:0]           i_instr,
   input  logic [ADDR_WIDTH-1:0] i_pc_plus2,
   output logic [15:0]           o_instr,
   output logic [ADDR_WIDTH-1:0] o_pc_plus2,
   output logic                  o_valid
);

   logic [15:0]           r_instr;
   logic [ADDR_WIDTH-1:0] r_pc_plus2;
   logic                  r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr    <= 16'h0000;
         r_pc_plus2 <= '0;
         r_valid    <= 1'b0;
      end else if (i_squash) begin
         r_valid    <= 1'b0;
      end else if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus2 <= i_pc_plus2;
         r_valid    <= 1'b1;
      end
   end

   assign o_instr    = r_instr;
   assign o_pc_plus2 = r_pc_plus2;
   assign o_valid    = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID capture.
// Priority in RUN is redirect > stall > normal fetch.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_D,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   =
      ADDR_WIDTH'(RESET_PC_D),
   parameter logic [3:0]            HLT_OPCODE = HLT_OPCODE_D
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [15:0]           imem_data,
   output logic [15:0]           ifid_instr,
   output logic [ADDR_WIDTH-1:0] ifid_pc_plus2,
   output logic                  ifid_valid,
   output logic                  halted,
   output logic                  misalign
);

   localparam logic [ADDR_WIDTH-1:0] PC_RST =
      {RESET_PC[ADDR_WIDTH-1:1], 1'b0};

   fetch_state_t          r_state;
   fetch_state_t          w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_plus2;
   logic [ADDR_WIDTH-1:0] w_redir_pc;
   logic                  r_mis;
   logic                  w_mis_nxt;
   logic                  w_load;
   logic                  w_squash;
   logic                  w_hlt;

   assign w_pc_plus2 = r_pc + ADDR_WIDTH'(2);
   assign w_redir_pc = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
   assign w_hlt      = (imem_data[15:12] == HLT_OPCODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= PC_RST;
         r_mis   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_mis   <= w_mis_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_mis_nxt   = r_mis;
      w_load      = 1'b0;
      w_squash    = 1'b0;
      unique case (r_state)
         BOOT: begin
            w_state_nxt = RUN;
         end
         RUN: begin
            if (redirect) begin
               w_pc_nxt  = w_redir_pc;
               w_squash  = 1'b1;
               w_mis_nxt = r_mis | redirect_pc[0];
            end else if (!stall) begin
               w_load = 1'b1;
               if (w_hlt) w_state_nxt = HALT;
               else       w_pc_nxt    = w_pc_plus2;
            end
         end
         HALT: begin
            // HLT was already captured; keep decode fed bubbles
            w_squash = 1'b1;
            if (redirect) begin
               w_pc_nxt    = w_redir_pc;
               w_mis_nxt   = r_mis | redirect_pc[0];
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   instr_fetch_ifid_reg #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ifid (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_squash   (w_squash),
      .i_instr    (imem_data),
      .i_pc_plus2 (w_pc_plus2),
      .o_instr    (ifid_instr),
      .o_pc_plus2 (ifid_pc_plus2),
      .o_valid    (ifid_valid)
   );

   assign imem_addr = r_pc;
   assign halted    = (r_state == HALT);
   assign misalign  = r_mis;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares them.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        ifid_valid;
   logic        halted;
   logic        misalign;

   logic [15:0] mem [0:32767];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] pc2;
      logic        valid;
      logic        halted;
      logic        mis;
   } exp_t;

   exp_t q[$];

   int errors = 0;
   int checks = 0;

   // model: 0 = boot, 1 = run, 2 = halt
   int          m_mode;
   logic [15:0] m_pc;
   logic [15:0] m_instr;
   logic [15:0] m_pc2;
   logic        m_valid;
   logic        m_mis;

   instr_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .ifid_valid    (ifid_valid),
      .halted        (halted),
      .misalign      (misalign)
   );

   assign imem_data = mem[imem_addr[15:1]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 16'h0000;
      m_instr = 16'h0000;
      m_pc2   = 16'h0000;
      m_valid = 1'b0;
      m_mis   = 1'b0;
   endtask

   task automatic model_redirect(input logic [15:0] rp);
      m_pc    = {rp[15:1], 1'b0};
      m_valid = 1'b0;
      m_mis   = m_mis | rp[0];
   endtask

   task automatic check_reset_outputs();
      chk("rst_addr",  imem_addr, 16'h0000);
      chk("rst_instr", ifid_instr, 16'h0000);
      chk("rst_pc2",   ifid_pc_plus2, 16'h0000);
      chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
      chk("rst_halt",  {15'd0, halted}, 16'd0);
      chk("rst_mis",   {15'd0, misalign}, 16'd0);
   endtask

   // Drive one cycle of inputs, advance the model across the edge.
   task automatic step(input logic s, input logic r,
                       input logic [15:0] rp);
      logic [15:0] w;
      exp_t e;
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      @(posedge clk);
      w = mem[m_pc[15:1]];
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (r) model_redirect(rp);
         else if (!s) begin
            m_instr = w;
            m_pc2   = m_pc + 16'd2;
            m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_mode = 2;
            else                  m_pc   = m_pc + 16'd2;
         end
      end else begin
         if (r) begin
            model_redirect(rp);
            m_mode = 1;
         end else begin
            m_valid = 1'b0;
         end
      end
      e.addr   = m_pc;
      e.instr  = m_instr;
      e.pc2    = m_pc2;
      e.valid  = m_valid;
      e.halted = (m_mode == 2);
      e.mis    = m_mis;
      q.push_back(e);
      #2;
   endtask

   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      stall    = 1'b0;
      redirect = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("addr",  imem_addr, e.addr);
            chk("instr", ifid_instr, e.instr);
            chk("pc2",   ifid_pc_plus2, e.pc2);
            chk("valid", {15'd0, ifid_valid}, {15'd0, e.valid});
            chk("halt",  {15'd0, halted}, {15'd0, e.halted});
            chk("mis",   {15'd0, misalign}, {15'd0, e.mis});
         end
      end
   end

   initial begin : stim
      logic [31:0] rnd;
      logic [15:0] rp;
      logic        s;
      logic        r;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      for (int i = 0; i < 32768; i++) begin
         rnd    = $urandom();
         mem[i] = rnd[15:0];
      end
      mem[0]      = 16'h1111;
      mem[1]      = 16'h2222;
      mem[2]      = 16'h3333;
      mem[3]      = 16'hF000;
      mem[8]      = 16'h4444;
      mem[9]      = 16'h5555;
      mem[16'h20] = 16'h6666;
      mem[16'h21] = 16'h7777;
      mem[16'h7FFF] = 16'h1234;
      mem[0]      = 16'h1111;
      model_reset();
      #7;
      check_reset_outputs();
      #5;
      rst_n = 1'b1;

      step(0, 0, 16'h0);
      chk("boot_valid", {15'd0, ifid_valid}, 16'd0);
      step(0, 0, 16'h0);
      chk("first_instr", ifid_instr, 16'h1111);
      step(0, 0, 16'h0);
      step(1, 0, 16'h0);
      step(1, 0, 16'h0);
      chk("stall_instr", ifid_instr, 16'h2222);
      chk("stall_addr", imem_addr, 16'h0004);
      step(0, 0, 16'h0);
      chk("resume_instr", ifid_instr, 16'h3333);
      step(0, 0, 16'h0);
      chk("hlt_valid", {15'd0, ifid_valid}, 16'd1);
      chk("hlt_halted", {15'd0, halted}, 16'd1);
      for (int i = 0; i < 10; i++) begin
         step(i[0], 0, 16'h0);
         chk("hlt_addr", imem_addr, 16'h0006);
      end
      step(0, 1, 16'h0010);
      chk("unhalt", {15'd0, halted}, 16'd0);
      step(0, 0, 16'h0);
      chk("tgt_instr", ifid_instr, 16'h4444);
      step(0, 0, 16'h0);
      step(1, 1, 16'h0041);
      chk("mis_addr", imem_addr, 16'h0040);
      chk("mis_flag", {15'd0, misalign}, 16'd1);
      step(0, 0, 16'h0);
      step(0, 0, 16'h0);
      chk("mis_sticky", {15'd0, misalign}, 16'd1);

      async_reset();
      for (int i = 0; i < 500; i++) begin
         rnd = $urandom();
         s   = (rnd[1:0] == 2'b00);
         r   = (rnd[4:2] == 3'b000);
         rp  = rnd[31:16];
         if (rnd[6:5] != 2'b00) rp[0] = 1'b0;
         step(s, r, rp);
      end

      step(0, 1, 16'hFFFE);
      step(0, 0, 16'h0);
      chk("wrap_addr", imem_addr, 16'h0000);
      chk("wrap_pc2", ifid_pc_plus2, 16'h0000);
      step(0, 0, 16'h0);
      async_reset();
      step(0, 0, 16'h0);
      step(0, 0, 16'h0);
      chk("post_rst", ifid_instr, 16'h1111);
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, need 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
